// File: rtl/rcastudio_pkg.sv
// Shared types for the Studio II cartridge loader: index constant, loader state, FIFO entry.
// Latency: n/a (types only).
// Backpressure: n/a.
package rcastudio_pkg;

    localparam logic [7:0] CART_IDX    = 8'h01;
    localparam int         CART_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } ld_state_t;

    typedef struct packed {
        logic [CART_ADDR_W-1:0] addr;
        logic [7:0]             data;
    } cart_wr_t;

endpackage

// File: rtl/cart_wr_fifo.sv
// Synchronous FIFO of cartridge write entries with flush; head is visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internal; the producer watches count/full, a push into a full FIFO is dropped.
import rcastudio_pkg::*;

module cart_wr_fifo #(
    parameter int  DEPTH = 4,
    parameter int  CW    = $clog2(DEPTH) + 1,
    parameter type T     = cart_wr_t
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  T              wr_dat,
    input  logic          pop,
    output T              rd_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // flush dominates so a restart never sees stale entries
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cart_ioctl_loader.sv
// hps_io download receiver: filters the cart index, buffers bytes, writes cart RAM over req/ack.
// Latency: 2 cycles ioctl_wr -> mem_req with an empty FIFO; 1 write/cycle with mem_ack high.
// Backpressure: registered ioctl_wait at count >= FIFO_DEPTH-1. CART_CHECKSUM_EN builds cart_sum.
import rcastudio_pkg::*;

module cart_ioctl_loader #(
    parameter logic [7:0] CART_INDEX = CART_IDX,
    parameter int         ADDR_W     = 12,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cart_valid,
    output logic [ADDR_W:0]   cart_size,
    output logic              cart_overflow,
    output logic              load_done,
    output logic [15:0]       cart_sum
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    ld_state_t       state;
    logic            active;
    logic            active_q;
    logic            act_rise;
    logic            act_fall;
    logic            in_range;
    logic            wr_load;
    logic            push;
    logic            pop;
    logic            flush;
    logic [ADDR_W:0] push_end;
    wr_t             push_dat;
    wr_t             head_dat;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    assign active   = ioctl_download && (ioctl_index == CART_INDEX);
    assign act_rise = active && !active_q;
    assign act_fall = !active && active_q;
    assign in_range = ~|ioctl_addr[24:ADDR_W];
    assign wr_load  = (state == LOAD) && active && ioctl_wr;
    assign push     = wr_load && in_range;
    assign push_end = {1'b0, ioctl_addr[ADDR_W-1:0]} + 1'b1;
    assign push_dat = '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};

    // a restart while bytes are still queued discards them; the in-flight write still completes
    assign flush = act_rise && (state != IDLE);
    assign pop   = (!mem_req || mem_ack) && !fifo_empty && !flush;

    cart_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW),
        .T     (wr_t)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .wr_dat  (push_dat),
        .pop     (pop),
        .rd_dat  (head_dat),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            active_q   <= 1'b0;
            cart_valid <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            active_q  <= active;
            load_done <= 1'b0;
            if (act_rise) begin
                state      <= LOAD;
                cart_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE:  state <= IDLE;
                    LOAD:  if (act_fall) state <= DRAIN;
                    DRAIN: begin
                        if (fifo_empty && !mem_req) begin
                            state      <= IDLE;
                            cart_valid <= 1'b1;
                            load_done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cart_size     <= '0;
            cart_overflow <= 1'b0;
        end else if (act_rise) begin
            cart_size     <= '0;
            cart_overflow <= 1'b0;
        end else begin
            // addr < CART_MAX on every push, so the running max saturates at CART_MAX by itself
            if (push && (push_end > cart_size)) cart_size <= push_end;
            if (wr_load && !in_range)           cart_overflow <= 1'b1;
        end
    end

`ifdef CART_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 16'h0000;
        end else if (act_rise) begin
            sum_q <= 16'h0000;
        end else if (push) begin
            sum_q <= sum_q + {8'h00, ioctl_dout};
        end
    end

    assign cart_sum = sum_q;
`else
    assign cart_sum = 16'h0000;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= 8'h00;
            ioctl_wait <= 1'b0;
        end else begin
            ioctl_wait <= (fifo_count >= CW'(FIFO_DEPTH - 1));
            if (pop) begin
                mem_req  <= 1'b1;
                mem_addr <= head_dat.addr;
                mem_data <= head_dat.data;
            end else if (mem_ack) begin
                mem_req  <= 1'b0;
            end
        end
    end

    // the registered ioctl_wait leaves room for exactly one late strobe; more is a bug upstream
    assert property (@(posedge clk_sys) disable iff (!reset_n) !(push && fifo_full && !pop));

endmodule
